// File: rtl/branch_predictor_bht_pkg.sv
// Shared widths and counter helpers for the branch history predictor.
package branch_predictor_bht_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned PERF_W = 32;
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    // Reset value of a cnt_w-bit counter: weakly not-taken.
    function automatic int unsigned ctr_init(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
    endfunction

    // One saturating step of a cnt_w-bit counter towards the resolved outcome.
    function automatic int unsigned ctr_step(input int unsigned cnt,
                                             input int unsigned cnt_w,
                                             input logic        up);
        int unsigned top;
        top = (32'd1 << cnt_w) - 32'd1;
        if (up) begin
            return (cnt == top) ? cnt : cnt + 32'd1;
        end
        return (cnt == 32'd0) ? cnt : cnt - 32'd1;
    endfunction

    // Performance counter increment that sticks at all-ones.
    function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
        return (v == PERF_MAX) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_btb.sv
// Tagged branch target buffer: one combinational read port, one write port.
module branch_predictor_bht_btb
    import branch_predictor_bht_pkg::*;
#(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [PC_W-1:0]  target,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target
);

    localparam int unsigned ENTRIES = 32'd1 << IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];

    // Valid bits are the only reset state; entries are never invalidated.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload, qualified by valid so no reset needed.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_target;
        end
    end

    assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign target = hit ? tgt_q[rd_idx] : '0;

endmodule

// File: rtl/branch_predictor_bht.sv
// Saturating-counter branch predictor with optional gshare history and tagged BTB.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned GHR_W  = 0,
    parameter int unsigned BTB_EN = 1,
    parameter int unsigned TAG_W  = 8,
    localparam int unsigned GW    = (GHR_W > 0) ? GHR_W : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       lookup_pc,
    output logic              pred_taken,
    output logic              pred_hit,
    output logic [31:0]       pred_target,
    output logic [GW-1:0]     pred_ghr,
    input  logic              upd_we,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic [GW-1:0]     upd_ghr,
    input  logic              upd_mispred,
    output logic [31:0]       perf_branch,
    output logic [31:0]       perf_mispred
);

    localparam int unsigned ENTRIES = 32'd1 << IDX_W;
    localparam int unsigned TAG_LO  = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ctr_init(CNT_W));

    if (GHR_W > IDX_W) begin : g_bad_ghr
        $error("GHR_W (%0d) must not exceed IDX_W (%0d)", GHR_W, IDX_W);
    end
    if (TAG_LO + TAG_W > PC_W) begin : g_bad_tag
        $error("IDX_W + TAG_W + 2 (%0d) exceeds the pc width", TAG_LO + TAG_W);
    end

    logic [IDX_W-1:0]  lk_hist;
    logic [IDX_W-1:0]  up_hist;
    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  up_idx;
    logic [CNT_W-1:0]  cnt_q [ENTRIES];
    logic [PERF_W-1:0] branch_q;
    logic [PERF_W-1:0] mispred_q;

    if (GHR_W > 0) begin : g_gshare
        logic [GHR_W-1:0] ghr_q;

        // Non-speculative history: shifts only when EX resolves a branch.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                ghr_q <= '0;
            end else if (upd_we) begin
                ghr_q <= GHR_W'({ghr_q, upd_taken});
            end
        end

        assign lk_hist  = IDX_W'(ghr_q);
        assign up_hist  = IDX_W'(upd_ghr);
        assign pred_ghr = ghr_q;
    end else begin : g_bimodal
        assign lk_hist  = '0;
        assign up_hist  = '0;
        assign pred_ghr = '0;
    end

    // Update uses the history carried with the branch, never the live GHR.
    assign lk_idx     = lookup_pc[IDX_W+1:2] ^ lk_hist;
    assign up_idx     = upd_pc[IDX_W+1:2] ^ up_hist;
    assign pred_taken = cnt_q[lk_idx][CNT_W-1];

    // Direction counter table.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (upd_we) begin
            cnt_q[up_idx] <= CNT_W'(ctr_step(32'(cnt_q[up_idx]), CNT_W, upd_taken));
        end
    end

    if (BTB_EN != 0) begin : g_btb
        branch_predictor_bht_btb #(
            .IDX_W (IDX_W),
            .TAG_W (TAG_W)
        ) u_btb (
            .clk       (clk),
            .rstn      (rstn),
            .rd_idx    (lookup_pc[IDX_W+1:2]),
            .rd_tag    (lookup_pc[TAG_LO+TAG_W-1:TAG_LO]),
            .hit       (pred_hit),
            .target    (pred_target),
            .we        (upd_we && upd_taken),
            .wr_idx    (upd_pc[IDX_W+1:2]),
            .wr_tag    (upd_pc[TAG_LO+TAG_W-1:TAG_LO]),
            .wr_target (upd_target)
        );
    end else begin : g_no_btb
        assign pred_hit    = 1'b0;
        assign pred_target = '0;
    end

    // Saturating resolved-branch and mispredict counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (upd_we) begin
            branch_q <= perf_inc(branch_q);
            if (upd_mispred) begin
                mispred_q <= perf_inc(mispred_q);
            end
        end
    end

    assign perf_branch  = branch_q;
    assign perf_mispred = mispred_q;

    // Pc bits outside the index/tag fields are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{lookup_pc, upd_pc, upd_ghr, upd_target};

endmodule
